ct_spsram_256x196_arb: RTL and testbench
========================================

CT_SPSRAM_256X196_ARB -- requirements
Module: ct_spsram_256x196_arb

Interface
REQ-001 Parameter ADDR_WIDTH, 8, SRAM index width (256 entries) SHALL be provided.
REQ-002 Parameter DATA_WIDTH, 196, SRAM word width SHALL be provided.
REQ-003 forever_cpuclk  in  1  sole clock; all state SHALL be on its rising edge.
REQ-004 cpurst_b  in  1  reset SHALL be asynchronous, active-low.
REQ-005 wr_req  in  1  write request; held until wr_gnt.
REQ-006 wr_idx  in  ADDR_WIDTH  write index.
REQ-007 wr_din  in  DATA_WIDTH  write data.
REQ-008 wr_mask  in  DATA_WIDTH  per-bit write enable, 1 = write bit.
REQ-009 wr_gnt  out  1  write accepted this cycle.
REQ-010 rd_req  in  1  read request; held until rd_gnt.
REQ-011 rd_idx  in  ADDR_WIDTH  read index.
REQ-012 rd_gnt  out  1  read accepted this cycle.
REQ-013 rd_vld  out  1  read data valid, registered.
REQ-014 rd_dout  out  DATA_WIDTH  read data, meaningful only with rd_vld.
REQ-015 init_done  out  1  array initialised; grants permitted.
REQ-016 sram_cen  out  1  SRAM chip enable, active-low.
REQ-017 sram_gwen  out  1  SRAM global write enable, active-low.
REQ-018 sram_wen  out  DATA_WIDTH  SRAM per-bit write enable, active-low.
REQ-019 sram_a  out  ADDR_WIDTH  SRAM address.
REQ-020 sram_d  out  DATA_WIDTH  SRAM write data.
REQ-021 sram_q  in  DATA_WIDTH  SRAM read data, valid one cycle after a read access.

Function
REQ-022 States: INIT (zero-fill sweep) and RUN; INIT -> RUN when sweep counter reaches 255 and that write has been issued.
REQ-023 In INIT: sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=sweep counter; counter increments 0..255, one entry per cycle; wr_gnt=rd_gnt=0.
REQ-024 init_done SHALL be 0 in INIT, 1 in RUN, registered.
REQ-025 In RUN, at most one of wr_gnt/rd_gnt SHALL be asserted per cycle; grant is combinational from req and arbiter state.
REQ-026 Single requester: granted the same cycle it requests.
REQ-027 Both requesting: round-robin; last_wr flag (1 = last grant was write) selects read when 1, write when 0; flag updates on every grant.
REQ-028 Write grant: sram_cen=0, sram_gwen=0, sram_wen=~wr_mask, sram_a=wr_idx, sram_d=wr_din.
REQ-029 wr_mask all zero on a write grant SHALL still consume the grant, with sram_gwen=1 (no array change).
REQ-030 Read grant: sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_a=rd_idx; rd_vld=1 exactly one cycle later, rd_dout=sram_q.
REQ-031 No grant: sram_cen=1, sram_gwen=1, sram_wen=all 1; sram_a and sram_d SHALL be held at last driven values.
REQ-032 Back-to-back reads SHALL sustain one read per cycle; rd_vld pulses per read.
REQ-033 Same-index write then read in consecutive grants: read SHALL return new data; no bypass path exists or is needed.
REQ-034 Requests arriving in INIT SHALL wait, not be dropped; served from first RUN cycle.

Reset
REQ-035 On cpurst_b=0: state=INIT (or RUN per REQ-038), sweep counter=0, last_wr=0, rd_vld=0, init_done=0, sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
REQ-036 Reset asserted mid-sweep or mid-read SHALL abort; sweep restarts from 0, pending rd_vld cleared.

Configuration
REQ-037 Macro CT_SPSRAM_ARB_INIT_EN defined: INIT sweep per REQ-022..024 (256 cycles after reset release).
REQ-038 Macro undefined: no sweep counter; reset state is RUN, init_done=1 from first cycle after reset release; array contents undefined.

Structure
REQ-039 Shared package ct_spsram_arb_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults, state encoding (INIT=1'b0, RUN=1'b1) and SWEEP_LAST=8'd255.
REQ-040 Round-robin selection SHALL be a sub-module ct_spsram_rr_arb2 (two requesters, last-grant flag in, grant vector out).
REQ-041 Arbiter SHALL drive the SRAM macro directly; no extra pipeline stage between grant and SRAM pins.

Verification
REQ-042 Reset release with INIT_EN -> 256 sweep writes, addresses 0..255, init_done rises on cycle 257; reading idx 8'h3A returns 196'h0.
REQ-043 Write idx 8'h10, data all 1s, mask all 1s; then read idx 8'h10 -> rd_vld one cycle after rd_gnt, rd_dout all 1s.
REQ-044 Write idx 8'h10 with mask bits[47:0] only, data 0 -> read returns bits[47:0]=0, bits[195:48]=1.
REQ-045 wr_req and rd_req held 6 cycles -> grants alternate W,R,W,R,W,R; never both high.
REQ-046 Assert cpurst_b=0 at sweep index 100 -> outputs to reset values; after release sweep restarts at 0.
REQ-047 Without INIT_EN: rd_req idx 0 in first cycle after reset release -> rd_gnt same cycle, rd_vld next cycle.

Source files
------------

// File: rtl/ct_spsram_arb_pkg.sv
// ct_spsram_arb_pkg: shared widths, state encoding and sweep bound for the SRAM arbiter.
//   ADDR_WIDTH / DATA_WIDTH : default geometry (256 x 196)
//   state_e                 : INIT (zero-fill sweep) = 0, RUN = 1
//   SWEEP_LAST              : last index written by the init sweep
package ct_spsram_arb_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 196;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
  localparam logic [7:0] SWEEP_LAST = 8'd255;
endpackage

// File: rtl/ct_spsram_rr_arb2.sv
// ct_spsram_rr_arb2: two-requester round-robin grant selection.
//   req[0]/gnt[0] : write requester
//   req[1]/gnt[1] : read requester
//   last_wr       : 1 = last grant went to write, so read wins a tie
module ct_spsram_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_wr,
  output logic [1:0] gnt
);
  import ct_spsram_arb_pkg::*;
  always_comb begin
    gnt[0] = req[0] & (~req[1] | ~last_wr);
    gnt[1] = req[1] & (~req[0] | last_wr);
  end
endmodule

// File: rtl/ct_spsram_256x196_arb.sv
// ct_spsram_256x196_arb: single-port SRAM front end arbitrating one write and one read port.
//   forever_cpuclk, cpurst_b (async, active-low)
//   wr_req/wr_idx/wr_din/wr_mask -> wr_gnt   : masked write port
//   rd_req/rd_idx -> rd_gnt, rd_vld/rd_dout  : read port, data one cycle after grant
//   init_done                                : array ready, grants permitted
//   sram_cen/gwen/wen/a/d, sram_q            : direct SRAM macro pins (active-low enables)
//   Macro CT_SPSRAM_ARB_INIT_EN enables a zero-fill sweep of every entry after reset.
module ct_spsram_256x196_arb #(
  parameter int ADDR_WIDTH = ct_spsram_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ct_spsram_arb_pkg::DATA_WIDTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  import ct_spsram_arb_pkg::*;
  state_e                state;
  logic                  in_init, run, wg, rg, last_wr;
  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] cnt, a_q;
  logic [DATA_WIDTH-1:0] d_q;
`ifdef CT_SPSRAM_ARB_INIT_EN
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt   <= cnt + 1'b1;
      state <= (cnt == ADDR_WIDTH'(SWEEP_LAST)) ? RUN : INIT;
    end
  assign init_done = (state == RUN);
`else
  assign state = RUN;
  assign cnt   = '0;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) init_done <= 1'b0;
    else           init_done <= 1'b1;
`endif
  // Pins are combinational from state and requests, so reset must gate them directly.
  assign in_init = cpurst_b & (state == INIT);
  assign run     = cpurst_b & (state == RUN);
  ct_spsram_rr_arb2 u_arb (
    .req     ({rd_req & run, wr_req & run}),
    .last_wr (last_wr),
    .gnt     (gnt)
  );
  always_comb begin
    wg        = gnt[0];
    rg        = gnt[1];
    wr_gnt    = wg;
    rd_gnt    = rg;
    sram_cen  = ~(in_init | wg | rg);
    // An all-zero mask still takes the grant but must not write the array.
    sram_gwen = ~(in_init | (wg & |wr_mask));
    sram_wen  = in_init ? '0 : wg ? ~wr_mask : '1;
    sram_a    = in_init ? cnt : wg ? wr_idx : rg ? rd_idx : a_q;
    sram_d    = in_init ? '0 : wg ? wr_din : d_q;
    rd_dout   = sram_q;
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      a_q     <= '0;
      d_q     <= '0;
      last_wr <= 1'b0;
      rd_vld  <= 1'b0;
    end else begin
      a_q     <= sram_a;
      d_q     <= sram_d;
      rd_vld  <= rg;
      if (wg | rg) last_wr <= wg;
    end
endmodule

// File: tb/tb_ct_spsram_256x196_arb.sv
// tb_ct_spsram_256x196_arb: randomized bench with a behavioural SRAM and reference model.
module tb_ct_spsram_256x196_arb;
  localparam int AW = 8, DW = 196;
`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_b = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_idx = '0, rd_idx = '0;
  logic [DW-1:0] wr_din = '0, wr_mask = '0;
  logic wr_gnt, rd_gnt, rd_vld, init_done, sram_cen, sram_gwen;
  logic [DW-1:0] rd_dout, sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  int n_err = 0, n_chk = 0;
  bit m_sweep, m_last_wr, m_pend, m_id;
  logic [AW-1:0] m_cnt, m_a;
  logic [DW-1:0] m_d, m_pdata;
  logic obs_wg, obs_rg, obs_vld;
  logic [DW-1:0] obs_dout;
  logic [AW-1:0] obs_a;

  ct_spsram_256x196_arb dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .wr_req         (wr_req),
    .wr_idx         (wr_idx),
    .wr_din         (wr_din),
    .wr_mask        (wr_mask),
    .wr_gnt         (wr_gnt),
    .rd_req         (rd_req),
    .rd_idx         (rd_idx),
    .rd_gnt         (rd_gnt),
    .rd_vld         (rd_vld),
    .rd_dout        (rd_dout),
    .init_done      (init_done),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd();
    logic [223:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Behavioural SRAM macro: active-low enables, read data one cycle after access.
  always @(posedge clk)
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] = (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= mem[sram_a];
    end

  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // One cycle: sample outputs #1 after the driving negedge, compare with the model,
  // advance the model across the coming posedge, then return at the next negedge.
  task automatic tick();
    bit ew, er, xcen, xgwen;
    logic [DW-1:0] xwen, xd;
    logic [AW-1:0] xa;
    #1;
    obs_wg = wr_gnt; obs_rg = rd_gnt; obs_vld = rd_vld; obs_dout = rd_dout; obs_a = sram_a;
    if (!rst_b) begin
      m_sweep = INIT_EN; m_cnt = '0; m_last_wr = 0; m_pend = 0; m_id = 0; m_a = '0; m_d = '0;
      chk("rst_wr_gnt", wr_gnt, 0);
      chk("rst_rd_gnt", rd_gnt, 0);
      chk("rst_rd_vld", rd_vld, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_cen", sram_cen, 1);
      chk("rst_gwen", sram_gwen, 1);
      chk("rst_wen", sram_wen, '1);
      chk("rst_a", sram_a, 0);
      chk("rst_d", sram_d, 0);
    end else begin
      ew = 0; er = 0;
      if (m_sweep) begin
        xcen = 0; xgwen = 0; xwen = '0; xa = m_cnt; xd = '0;
      end else begin
        if (wr_req && rd_req) begin ew = !m_last_wr; er = m_last_wr; end
        else begin ew = wr_req; er = rd_req; end
        xcen = !(ew || er);
        xgwen = !(ew && wr_mask != '0);
        xwen = ew ? ~wr_mask : '1;
        xa = ew ? wr_idx : er ? rd_idx : m_a;
        xd = ew ? wr_din : m_d;
      end
      chk("wr_gnt", wr_gnt, ew);
      chk("rd_gnt", rd_gnt, er);
      chk("init_done", init_done, m_id);
      chk("sram_cen", sram_cen, xcen);
      chk("sram_gwen", sram_gwen, xgwen);
      chk("sram_wen", sram_wen, xwen);
      chk("sram_a", sram_a, xa);
      chk("sram_d", sram_d, xd);
      chk("rd_vld", rd_vld, m_pend);
      if (m_pend) chk("rd_dout", rd_dout, m_pdata);
      if (m_sweep) begin
        ref_mem[m_cnt] = '0;
        m_sweep = (m_cnt != 8'd255);
        m_cnt = m_cnt + 1'b1;
      end else begin
        if (ew) begin
          ref_mem[wr_idx] = (ref_mem[wr_idx] & ~wr_mask) | (wr_din & wr_mask);
          m_last_wr = 1;
        end
        if (er) begin
          m_last_wr = 0;
          m_pdata = ref_mem[rd_idx];
        end
      end
      m_pend = er; m_a = xa; m_d = xd;
      m_id = INIT_EN ? !m_sweep : 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] din, input logic [DW-1:0] mask);
    int k;
    wr_req = 1; wr_idx = idx; wr_din = din; wr_mask = mask;
    for (k = 0; k < 20; k++) begin
      tick();
      if (obs_wg) break;
    end
    wr_req = 0;
    chk("wr_grant_timeout", k < 20, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] idx, output logic [DW-1:0] q);
    int k;
    rd_req = 1; rd_idx = idx;
    for (k = 0; k < 20; k++) begin
      tick();
      if (obs_rg) break;
    end
    rd_req = 0;
    chk("rd_grant_timeout", k < 20, 1);
    tick();
    chk("rd_vld_latency", obs_vld, 1);
    q = obs_dout;
  endtask

  initial begin
    logic [DW-1:0] q, m48;
    int k;
    for (int i = 0; i < 256; i++) begin
      mem[i] = INIT_EN ? rnd() : '0;
      ref_mem[i] = '0;
    end
    wr_req = 1; rd_req = 1; wr_idx = 8'h05; rd_idx = 8'h06; wr_din = rnd(); wr_mask = '1;
    @(negedge clk);
    tick();
    tick();
    wr_req = 0; rd_req = 0;
    if (INIT_EN) begin
      rst_b = 1;
      repeat (100) tick();
      chk("sweep_idx_99", obs_a, 8'd99);
      rst_b = 0;
      tick();
      rst_b = 1;
      rd_req = 1; rd_idx = 8'h3A;
      for (k = 0; k < 300; k++) begin
        tick();
        if (k == 0) chk("sweep_restart_a", obs_a, 0);
        if (obs_rg) break;
      end
      rd_req = 0;
      chk("init_wait_cycles", k, 256);
      tick();
      chk("lit_3a_vld", obs_vld, 1);
      chk("lit_3a_zero", obs_dout, '0);
    end else begin
      rd_req = 1; rd_idx = 8'h00;
      rst_b = 1;
      tick();
      chk("first_cycle_rd_gnt", obs_rg, 1);
      rd_req = 0;
      tick();
      chk("first_cycle_rd_vld", obs_vld, 1);
    end
    do_write(8'h10, '1, '1);
    do_read(8'h10, q);
    chk("lit_all_ones", q, '1);
    m48 = '0; m48[47:0] = '1;
    do_write(8'h10, '0, m48);
    do_read(8'h10, q);
    chk("lit_mask48", q, ~m48);
    do_write(8'h10, '0, '0);
    do_read(8'h10, q);
    chk("lit_zero_mask", q, ~m48);
    wr_req = 1; rd_req = 1; wr_idx = 8'h20; rd_idx = 8'h21; wr_din = rnd(); wr_mask = '1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("alt_w", obs_wg, i % 2 == 0);
      chk("alt_r", obs_rg, i % 2 == 1);
    end
    wr_req = 0; rd_req = 0;
    tick();
    for (int i = 0; i < 400; i++) begin
      if (!wr_req && $urandom_range(1, 0) == 1) begin
        wr_req = 1; wr_idx = AW'($urandom_range(7, 0)); wr_din = rnd();
        case ($urandom_range(2, 0))
          0: wr_mask = '1;
          1: wr_mask = '0;
          default: wr_mask = rnd();
        endcase
      end
      if (!rd_req && $urandom_range(1, 0) == 1) begin
        rd_req = 1; rd_idx = AW'($urandom_range(7, 0));
      end
      tick();
      if (obs_wg) wr_req = 0;
      if (obs_rg) rd_req = 0;
    end
    wr_req = 0; rd_req = 0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
